// File: rtl/datapath_ctrl.sv
// Instruction sequencer for the 16-bit register/ALU datapath: accepts one
// instruction over valid/ready, decodes it and steps a Moore FSM through the datapath controls.
module datapath_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             ready,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       shift,
    output logic [1:0]       ALUop,
    output logic [3:0]       vsel,
    output logic [15:0]      sximm8,
    output logic [15:0]      sximm5,
    output logic             done,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t           state_r;
    state_t           next_s;
    logic [15:0]      ir_r;
    logic [CNT_W-1:0] retired_r;

    logic [2:0] opcode_s;
    logic [1:0] op_s;
    logic       is_mov_imm_s;
    logic       is_mov_reg_s;
    logic       is_mvn_s;
    logic       is_alu_s;
    logic       is_cmp_s;
    logic       is_halt_s;

    assign opcode_s     = ir_r[15:13];
    assign op_s         = ir_r[12:11];
    assign is_mov_imm_s = (opcode_s == 3'b110) && (op_s == 2'b10);
    assign is_mov_reg_s = (opcode_s == 3'b110) && (op_s == 2'b00);
    assign is_mvn_s     = (opcode_s == 3'b101) && (op_s == 2'b11);
    assign is_alu_s     = (opcode_s == 3'b101) && ((op_s == 2'b00) || (op_s == 2'b10));
    assign is_cmp_s     = (opcode_s == 3'b101) && (op_s == 2'b01);
    assign is_halt_s    = (opcode_s == 3'b111);

    assign sximm8  = {{8{ir_r[7]}}, ir_r[7:0]};
    assign sximm5  = {{11{ir_r[4]}}, ir_r[4:0]};
    assign retired = retired_r;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_WAIT;
        end else begin
            state_r <= next_s;
        end
    end

    // Instruction register, loaded only on a handshake in WAIT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_r <= 16'h0000;
        end else if ((state_r == S_WAIT) && instr_valid) begin
            ir_r <= instr;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Retired-instruction counter; wraps silently
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_r <= '0;
        end else if (done) begin
            retired_r <= retired_r + CNT_W'(1);
        end else begin
            retired_r <= retired_r;
        end
    end

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_WAIT: begin
                if (instr_valid) next_s = S_DECODE;
                else             next_s = S_WAIT;
            end
            S_DECODE: begin
                if (is_mov_imm_s)                 next_s = S_WR_IMM;
                else if (is_mov_reg_s || is_mvn_s) next_s = S_GET_B;
                else if (is_alu_s || is_cmp_s)     next_s = S_GET_A;
                else if (is_halt_s)                next_s = S_HALT;
                else                               next_s = S_WAIT;
            end
            S_GET_A:  next_s = S_GET_B;
            S_GET_B:  next_s = S_EXEC;
            S_EXEC: begin
                if (is_cmp_s) next_s = S_WAIT;
                else          next_s = S_WR_REG;
            end
            S_WR_REG: next_s = S_WAIT;
            S_WR_IMM: next_s = S_WAIT;
            S_HALT:   next_s = S_HALT;
            default:  next_s = S_WAIT;
        endcase
    end

    // Moore output decode from state and IR
    always_comb begin
        ready    = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        vsel     = 4'b0001;
        done     = 1'b0;
        illegal  = 1'b0;
        halted   = 1'b0;
        case (state_r)
            S_WAIT: ready = 1'b1;
            S_DECODE: begin
                if (is_mov_imm_s || is_mov_reg_s || is_mvn_s || is_alu_s || is_cmp_s || is_halt_s) begin
                    illegal = 1'b0;
                end else begin
                    illegal = 1'b1;
                end
            end
            S_GET_A: begin
                readnum = ir_r[10:8];
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = ir_r[2:0];
                loadb   = 1'b1;
            end
            S_EXEC: begin
                shift = ir_r[4:3];
                // CMP only updates status and retires here, without a writeback
                if (is_mov_reg_s) begin
                    asel  = 1'b1;
                    ALUop = 2'b00;
                    loadc = 1'b1;
                end else if (is_mvn_s) begin
                    ALUop = 2'b11;
                    loadc = 1'b1;
                end else if (is_cmp_s) begin
                    ALUop = 2'b01;
                    loads = 1'b1;
                    done  = 1'b1;
                end else begin
                    ALUop = op_s;
                    loadc = 1'b1;
                end
            end
            S_WR_REG: begin
                writenum = ir_r[7:5];
                vsel     = 4'b1000;
                write    = 1'b1;
                done     = 1'b1;
            end
            S_WR_IMM: begin
                writenum = ir_r[10:8];
                vsel     = 4'b0010;
                write    = 1'b1;
                done     = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ready = 1'b0;
        endcase
    end

endmodule
